row_stream_seq: RTL and testbench

- Row sequencer that sits directly upstream and downstream of the 40-bit row subtractor. It feeds that unit and collects what it produces.
- Latches two 5x5 int8 matrices (5 rows x 40 bits each) on a start pulse. Issues one row pair per cycle to the external row-op unit.
- Captures each result row after a fixed latency, assembles the 200-bit result matrix and a sticky overflow flag, then pulses done.

---
 rtl/row_stream_seq.sv | 124 ++++++++++++
 tb/tb_row_stream_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/row_stream_seq.sv
// Row sequencer around the external 40-bit row subtractor: latches two matrices, issues one row pair per cycle,
// captures results after OP_LATENCY cycles. Optional per-row overflow mask output under `ROW_OVF_MASK_EN.
module row_stream_seq #(
  parameter int ROWS       = 5,
  parameter int ROW_W      = 40,
  parameter int OP_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ROWS*ROW_W-1:0] mat_a,
  input  logic [ROWS*ROW_W-1:0] mat_b,
  output logic [ROW_W-1:0]      op_row_a,
  output logic [ROW_W-1:0]      op_row_b,
  input  logic [ROW_W-1:0]      op_res,
  input  logic                  op_ovf,
`ifdef ROW_OVF_MASK_EN
  output logic [ROWS-1:0]       ovf_rows,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            row_idx,
  output logic [ROWS*ROW_W-1:0] mat_res,
  output logic                  ovf
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state;
  logic [ROW_W-1:0] a_rows   [ROWS];
  logic [ROW_W-1:0] b_rows   [ROWS];
  logic [ROW_W-1:0] res_rows [ROWS];
  logic             pipe_v   [OP_LATENCY];
  logic [2:0]       pipe_i   [OP_LATENCY];
  logic             pending;
  logic             capture;
  logic [2:0]       cap_idx;

  assign capture = pipe_v[OP_LATENCY-1];
  assign cap_idx = pipe_i[OP_LATENCY-1];

  // Entries ahead of the tail; once these are empty the tail holds the final capture.
  always_comb begin
    pending = 1'b0;
    for (int unsigned i = 0; i + 1 < OP_LATENCY; i++) pending = pending | pipe_v[i];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      row_idx <= '0;
      ovf     <= 1'b0;
`ifdef ROW_OVF_MASK_EN
      ovf_rows <= '0;
`endif
      for (int unsigned i = 0; i < ROWS; i++) begin
        res_rows[i] <= '0;
        a_rows[i]   <= '0;
        b_rows[i]   <= '0;
      end
      for (int unsigned i = 0; i < OP_LATENCY; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_i[i] <= '0;
      end
    end else begin
      pipe_v[0] <= (state == S_ISSUE);
      pipe_i[0] <= row_idx;
      for (int unsigned i = 1; i < OP_LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_i[i] <= pipe_i[i-1];
      end

      if (capture) begin
        res_rows[cap_idx] <= op_res;
        ovf               <= ovf | op_ovf;
`ifdef ROW_OVF_MASK_EN
        ovf_rows[cap_idx] <= op_ovf;
`endif
      end

      case (state)
        S_IDLE: begin
          row_idx <= '0;
          if (start) begin
            for (int unsigned i = 0; i < ROWS; i++) begin
              a_rows[i]   <= mat_a[ROW_W*(ROWS-i)-1 -: ROW_W];
              b_rows[i]   <= mat_b[ROW_W*(ROWS-i)-1 -: ROW_W];
              res_rows[i] <= '0;
            end
            ovf <= 1'b0;
`ifdef ROW_OVF_MASK_EN
            ovf_rows <= '0;
`endif
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (row_idx == 3'(ROWS-1)) begin
            row_idx <= '0;
            state   <= S_DRAIN;
          end else begin
            row_idx <= row_idx + 3'd1;
          end
        end
        S_DRAIN: if (!pending) state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy     = (state == S_ISSUE) || (state == S_DRAIN);
  assign done     = (state == S_DONE);
  assign op_row_a = (state == S_ISSUE) ? a_rows[row_idx] : '0;
  assign op_row_b = (state == S_ISSUE) ? b_rows[row_idx] : '0;

  always_comb begin
    mat_res = '0;
    for (int unsigned i = 0; i < ROWS; i++) mat_res[ROW_W*(ROWS-i)-1 -: ROW_W] = res_rows[i];
  end

endmodule

// File: tb/tb_row_stream_seq.sv
// Directed bench for row_stream_seq with behavioural row subtractor models (latency 1 and 3) and a result scoreboard.
module tb_row_stream_seq;

  logic         clk = 1'b0;
  logic         rst, start, start3;
  logic [199:0] mat_a, mat_b;

  logic [39:0]  op_row_a, op_row_b, op_res, op_row_a3, op_row_b3, op_res3;
  logic         op_ovf, op_ovf3, busy, done, ovf, busy3, done3, ovf3;
  logic [2:0]   row_idx, row_idx3;
  logic [199:0] mat_res, mat_res3;
  logic [4:0]   ovf_rows, ovf_rows3;

  typedef struct {
    logic [199:0] res;
    logic         ovf;
    logic [4:0]   rows;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  row_stream_seq #(.ROWS(5), .ROW_W(40), .OP_LATENCY(1)) dut (
    .clk(clk), .rst(rst), .start(start), .mat_a(mat_a), .mat_b(mat_b),
    .op_row_a(op_row_a), .op_row_b(op_row_b), .op_res(op_res), .op_ovf(op_ovf),
`ifdef ROW_OVF_MASK_EN
    .ovf_rows(ovf_rows),
`endif
    .busy(busy), .done(done), .row_idx(row_idx), .mat_res(mat_res), .ovf(ovf)
  );

  row_stream_seq #(.ROWS(5), .ROW_W(40), .OP_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .mat_a(mat_a), .mat_b(mat_b),
    .op_row_a(op_row_a3), .op_row_b(op_row_b3), .op_res(op_res3), .op_ovf(op_ovf3),
`ifdef ROW_OVF_MASK_EN
    .ovf_rows(ovf_rows3),
`endif
    .busy(busy3), .done(done3), .row_idx(row_idx3), .mat_res(mat_res3), .ovf(ovf3)
  );

`ifndef ROW_OVF_MASK_EN
  assign ovf_rows  = '0;
  assign ovf_rows3 = '0;
`endif

  function automatic logic [39:0] sub_row(input logic [39:0] a, input logic [39:0] b);
    logic [39:0] r;
    for (int l = 0; l < 5; l++) r[8*l +: 8] = a[8*l +: 8] - b[8*l +: 8];
    return r;
  endfunction

  function automatic logic ovf_row(input logic [39:0] a, input logic [39:0] b);
    logic       o = 1'b0;
    logic [7:0] d;
    for (int l = 0; l < 5; l++) begin
      d = a[8*l +: 8] - b[8*l +: 8];
      if (a[8*l+7] != b[8*l+7] && d[7] != a[8*l+7]) o = 1'b1;
    end
    return o;
  endfunction

  function automatic logic [39:0] get_row(input logic [199:0] m, input int i);
    return m[40*(5-i)-1 -: 40];
  endfunction

  // Behavioural row subtractors: 1-stage and 3-stage.
  logic [39:0] p3_res [3];
  logic        p3_ovf [3];
  always_ff @(posedge clk) begin
    op_res    <= sub_row(op_row_a, op_row_b);
    op_ovf    <= ovf_row(op_row_a, op_row_b);
    p3_res[0] <= sub_row(op_row_a3, op_row_b3);
    p3_ovf[0] <= ovf_row(op_row_a3, op_row_b3);
    p3_res[1] <= p3_res[0];
    p3_ovf[1] <= p3_ovf[0];
    p3_res[2] <= p3_res[1];
    p3_ovf[2] <= p3_ovf[1];
  end
  assign op_res3 = p3_res[2];
  assign op_ovf3 = p3_ovf[2];

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [199:0] ma, input logic [199:0] mb);
    exp_t e;
    e.res  = '0;
    e.ovf  = 1'b0;
    e.rows = '0;
    for (int i = 0; i < 5; i++) begin
      e.res[40*(5-i)-1 -: 40] = sub_row(get_row(ma, i), get_row(mb, i));
      e.rows[i] = ovf_row(get_row(ma, i), get_row(mb, i));
    end
    e.ovf = |e.rows;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input string tag, input logic [199:0] res, input logic o, input logic [4:0] rows);
    exp_t e;
    e = sb.pop_front();
    chk({tag, "_mat_res"}, res, e.res);
    chk({tag, "_ovf"}, 200'(o), 200'(e.ovf));
`ifdef ROW_OVF_MASK_EN
    chk({tag, "_ovf_rows"}, 200'(rows), 200'(e.rows));
`else
    if (rows !== 5'b0) chk({tag, "_ovf_rows_tied"}, 200'(rows), 200'd0);
`endif
  endtask

  // One run on the latency-1 DUT; start may be held (back-to-back runs) or pulsed during busy.
  task automatic run1(input logic [199:0] ma, input logic [199:0] mb,
                      input bit hold, input bit pulse, input bit scramble);
    int ncyc;
    int ph;
    ncyc = hold ? 16 : 8;
    push_exp(ma, mb);
    if (hold) push_exp(ma, mb);
    @(negedge clk);
    mat_a = ma;
    mat_b = mb;
    start = 1'b1;
    chk("c0_op_row_a", 200'(op_row_a), 200'd0);
    chk("c0_busy", 200'(busy), 200'd0);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      ph = c % 8;
      chk($sformatf("c%0d_op_row_a", c), 200'(op_row_a), (ph >= 1 && ph <= 5) ? 200'(get_row(ma, ph-1)) : 200'd0);
      chk($sformatf("c%0d_op_row_b", c), 200'(op_row_b), (ph >= 1 && ph <= 5) ? 200'(get_row(mb, ph-1)) : 200'd0);
      chk($sformatf("c%0d_row_idx", c), 200'(row_idx), (ph >= 1 && ph <= 5) ? 200'(ph-1) : 200'd0);
      chk($sformatf("c%0d_busy", c), 200'(busy), 200'(ph >= 1 && ph <= 6));
      chk($sformatf("c%0d_done", c), 200'(done), 200'(ph == 7));
      if (ph == 1) begin
        chk($sformatf("c%0d_res_cleared", c), mat_res, 200'd0);
        chk($sformatf("c%0d_ovf_cleared", c), 200'(ovf), 200'd0);
      end
      if (done && sb.size() > 0) pop_cmp($sformatf("c%0d", c), mat_res, ovf, ovf_rows);
      start = (hold && c < 15) || (pulse && (c == 3 || c == 6));
      if (scramble && c == 1) begin
        mat_a = ~ma;
        mat_b = ~mb;
      end
    end
    chk("sb_drained", 200'(sb.size()), 200'd0);
    sb.delete();
    start = 1'b0;
  endtask

  logic [199:0] ma_basic, mb_basic, ma_ord, ma_ovf, mb_ovf;

  initial begin
    rst    = 1'b0;
    start  = 1'b0;
    start3 = 1'b0;
    mat_a  = '0;
    mat_b  = '0;
    ma_basic = {5{40'h0505050505}};
    mb_basic = {5{40'h0303030303}};
    for (int i = 0; i < 5; i++) ma_ord[40*(5-i)-1 -: 40] = {5{8'(8'h11 * (i + 1))}};
    ma_ovf = {{3{40'h0505050505}}, 40'h8080808080, 40'h0505050505};
    mb_ovf = {{3{40'h0303030303}}, 40'h0101010101, 40'h0303030303};

    repeat (2) @(negedge clk);
    chk("rst_op_row_a", 200'(op_row_a), 200'd0);
    chk("rst_row_idx", 200'(row_idx), 200'd0);
    chk("rst_busy", 200'(busy), 200'd0);
    chk("rst_done", 200'(done), 200'd0);
    chk("rst_mat_res", mat_res, 200'd0);
    chk("rst_ovf", 200'(ovf), 200'd0);
    rst = 1'b1;

    // Basic run with inputs scrambled after acceptance.
    run1(ma_basic, mb_basic, 1'b0, 1'b0, 1'b1);
    // Row ordering.
    run1(ma_ord, '0, 1'b0, 1'b0, 1'b0);
    // Overflow on row 3, then a clean run with ignored start pulses clears it.
    run1(ma_ovf, mb_ovf, 1'b0, 1'b0, 1'b0);
    run1(ma_basic, mb_basic, 1'b0, 1'b1, 1'b0);
    // Start held high: back-to-back runs.
    run1(ma_ord, mb_basic, 1'b1, 1'b0, 1'b0);

    // Mid-ISSUE reset.
    @(negedge clk);
    mat_a = ma_ovf;
    mat_b = mb_ovf;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_row_idx_before", 200'(row_idx), 200'd2);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    chk("midrst_op_row_a", 200'(op_row_a), 200'd0);
    chk("midrst_row_idx", 200'(row_idx), 200'd0);
    chk("midrst_busy", 200'(busy), 200'd0);
    chk("midrst_ovf", 200'(ovf), 200'd0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("postrst%0d_done", c), 200'(done), 200'd0);
      chk($sformatf("postrst%0d_mat_res", c), mat_res, 200'd0);
      chk($sformatf("postrst%0d_busy", c), 200'(busy), 200'd0);
    end
    run1(ma_basic, mb_basic, 1'b0, 1'b0, 1'b0);

    // Latency-3 instance: done in cycle 9.
    push_exp(ma_ovf, mb_ovf);
    @(negedge clk);
    mat_a  = ma_ovf;
    mat_b  = mb_ovf;
    start3 = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      start3 = 1'b0;
      chk($sformatf("l3_c%0d_done", c), 200'(done3), 200'(c == 9));
      chk($sformatf("l3_c%0d_busy", c), 200'(busy3), 200'(c >= 1 && c <= 8));
      if (done3 && sb.size() > 0) pop_cmp("l3", mat_res3, ovf3, ovf_rows3);
    end
    chk("l3_sb_drained", 200'(sb.size()), 200'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
